// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types and defaults for the pc control sequencer
package pc_ctrl_pkg;

  localparam int DEFAULT_ADDR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    IT_NOP  = 2'b00,
    IT_REG  = 2'b01,
    IT_MEM  = 2'b10,
    IT_HALT = 2'b11
  } instr_type_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - datapath bus between the sequencer and the pc datapath/instruction memory
interface pc_sequencer_if
  import pc_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic [ADDR_W-1:0] instruction_A;
  logic [1:0]        instr_type;
  logic              RegWrite;
  logic              MemWrite;

  modport master (
    output instruction_A,
    output RegWrite,
    output MemWrite,
    input  instr_type
  );

  modport slave (
    input  instruction_A,
    input  RegWrite,
    input  MemWrite,
    output instr_type
  );

endinterface

// File: rtl/pc_sequencer_hold_timer.sv
// rtl/pc_sequencer_hold_timer.sv - loadable down-counter timing the EXEC hold window
module hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Saturates at zero so the count never wraps while the FSM idles elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multicycle sequencer walking instruction addresses and pulsing write enables
module pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              step_mode,
  input  logic              step,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  pc_sequencer_if.master    dp
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  instr_type_t       type_q;
  logic              type_held;
  instr_type_t       exec_type;
  logic              hold_zero;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == ST_FETCH),
    .zero (hold_zero)
  );

  // With a one-cycle hold the exit decision happens before the type is registered.
  assign exec_type = type_held ? type_q : instr_type_t'(dp.instr_type);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          addr_d  = '0;
          last_d  = last_addr;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (hold_zero) begin
          state_d = (exec_type == IT_HALT) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (addr_q == last_q) begin
          state_d = ST_DONE;
        end else if (step_mode) begin
          state_d = ST_PAUSE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_PAUSE: begin
        if (step) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      default: begin
        addr_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
    if (abort) begin
      addr_d  = '0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      last_q    <= '0;
      type_q    <= IT_NOP;
      type_held <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      if (state_q == ST_EXEC && !type_held) begin
        type_q    <= instr_type_t'(dp.instr_type);
        type_held <= 1'b1;
      end else if (state_q != ST_EXEC) begin
        type_held <= 1'b0;
      end
    end
  end

  assign dp.instruction_A = addr_q;
  assign dp.RegWrite      = (state_q == ST_WRITE) && (type_q == IT_REG);
  assign dp.MemWrite      = (state_q == ST_WRITE) && (type_q == IT_MEM);
  assign busy             = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done             = (state_q == ST_DONE);

endmodule
